// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch sequencer.
package fetch_pkg;

  localparam int unsigned PC_W_DEF  = 10;
  localparam int unsigned PTR_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_INC    = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_LOAD   = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/branch_target_lut.sv
// Absolute branch-target table; edit entries here per program. Unlisted index -> 0.
module branch_target_lut
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned PTR_W = PTR_W_DEF
) (
  input  logic [PTR_W-1:0] ptr,
  output logic [PC_W-1:0]  target_c
);

  always_comb begin
    target_c = '0;
    case (ptr)
      PTR_W'(1):  target_c = PC_W'(40);
      PTR_W'(2):  target_c = PC_W'(100);
      PTR_W'(3):  target_c = PC_W'(200);
      PTR_W'(5):  target_c = PC_W'(512);
      PTR_W'(15): target_c = PC_W'(1000);
      default:    target_c = '0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter controller: load, run (hold/+1/branch), halt or overflow to done.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned PTR_W = PTR_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             BranchTaken,
  input  logic [PTR_W-1:0] LutPointer,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             InstrValid,
  output logic             Done,
  output logic             Fault,
  output logic [CNT_W-1:0] CycleCount
);

  fetch_state_t     state_q, state_d;
  pc_sel_t          pc_sel;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  target_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;

  branch_target_lut #(
    .PC_W  (PC_W),
    .PTR_W (PTR_W)
  ) u_lut (
    .ptr      (LutPointer),
    .target_c (target_c)
  );

  // Next-state, PC select, counter and fault update.
  always_comb begin
    state_d = state_q;
    pc_sel  = SEL_HOLD;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pc_sel  = SEL_LOAD;
        cnt_d   = '0;
        fault_d = 1'b0;
        if (!Start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Every run cycle counts, stalls and the halt cycle included.
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (Start) begin
          state_d = ST_LOAD;
        end else if (Stall) begin
          pc_sel = SEL_HOLD;
        end else if (Halt) begin
          state_d = ST_DONE;
        end else if (BranchEn && BranchTaken) begin
          pc_sel = SEL_BRANCH;
        end else begin
          pc_sel = SEL_INC;
          if (pc_q == {PC_W{1'b1}}) begin
            fault_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next-PC mux; increment wraps to 0 on overflow.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      SEL_HOLD:   pc_d = pc_q;
      SEL_INC:    pc_d = pc_q + PC_W'(1);
      SEL_BRANCH: pc_d = target_c;
      SEL_LOAD:   pc_d = StartAddr;
      default:    pc_d = pc_q;
    endcase
  end

  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign ProgCtr    = pc_q;
  assign Done       = done_q;
  assign Fault      = fault_q;
  assign CycleCount = cnt_q;
  assign InstrValid = (state_q == ST_RUN) && !Stall && !Start;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table plus reset and saturation sequences.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start, Stall, Halt, BranchEn, BranchTaken;
  logic [9:0]  StartAddr;
  logic [3:0]  LutPointer;
  logic [9:0]  ProgCtr, pc4;
  logic        InstrValid, Done, Fault, iv4, done4, fault4;
  logic [15:0] CycleCount;
  logic [3:0]  cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  fetch_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .Halt(Halt), .BranchEn(BranchEn), .BranchTaken(BranchTaken),
    .LutPointer(LutPointer), .ProgCtr(ProgCtr), .InstrValid(InstrValid),
    .Done(Done), .Fault(Fault), .CycleCount(CycleCount)
  );

  fetch_sequencer #(.CNT_W(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .Halt(Halt), .BranchEn(BranchEn), .BranchTaken(BranchTaken),
    .LutPointer(LutPointer), .ProgCtr(pc4), .InstrValid(iv4),
    .Done(done4), .Fault(fault4), .CycleCount(cnt4)
  );

  typedef struct {
    logic        start;
    logic [9:0]  addr;
    logic        stall, halt, ben, bt;
    logic [3:0]  ptr;
    logic        valid;
    logic [9:0]  pc;
    logic        done, fault;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int s, input int a, input int st, input int h,
                     input int be, input int bt, input int p, input int v,
                     input int pc, input int d, input int f, input int c);
    vec_t x;
    x.start = 1'(s);  x.addr = 10'(a); x.stall = 1'(st); x.halt = 1'(h);
    x.ben = 1'(be);   x.bt = 1'(bt);   x.ptr = 4'(p);    x.valid = 1'(v);
    x.pc = 10'(pc);   x.done = 1'(d);  x.fault = 1'(f);  x.cnt = 16'(c);
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int s, input int a, input int st, input int h,
                       input int be, input int bt, input int p);
    Start = 1'(s); StartAddr = 10'(a); Stall = 1'(st); Halt = 1'(h);
    BranchEn = 1'(be); BranchTaken = 1'(bt); LutPointer = 4'(p);
  endtask

  initial begin
    Reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_pc", int'(ProgCtr), 0);
    chk("reset_done", int'(Done), 0);
    chk("reset_fault", int'(Fault), 0);
    chk("reset_cnt", int'(CycleCount), 0);
    chk("reset_valid", int'(InstrValid), 0);

    //  st  addr stl hlt ben bt ptr | vld pc  dn flt cnt
    add(1,  14,  0,  0,  0,  0, 0,    0,  0,   0, 0, 0);
    add(1,  14,  0,  0,  0,  0, 0,    0,  14,  0, 0, 0);
    add(1,  14,  0,  0,  0,  0, 0,    0,  14,  0, 0, 0);
    add(0,  14,  0,  0,  0,  0, 0,    0,  14,  0, 0, 0);
    add(0,  0,   0,  0,  0,  0, 0,    1,  15,  0, 0, 1);
    add(0,  0,   0,  0,  0,  0, 0,    1,  16,  0, 0, 2);
    add(0,  0,   0,  0,  0,  0, 0,    1,  17,  0, 0, 3);
    add(0,  0,   0,  0,  0,  0, 0,    1,  18,  0, 0, 4);
    add(0,  0,   0,  0,  0,  0, 0,    1,  19,  0, 0, 5);
    add(0,  0,   0,  0,  0,  0, 0,    1,  20,  0, 0, 6);
    add(0,  0,   0,  0,  1,  1, 2,    1,  100, 0, 0, 7);
    add(0,  0,   0,  0,  1,  0, 2,    1,  101, 0, 0, 8);
    add(0,  0,   0,  0,  1,  1, 7,    1,  0,   0, 0, 9);
    add(0,  0,   0,  0,  1,  1, 1,    1,  40,  0, 0, 10);
    add(0,  0,   1,  1,  0,  0, 0,    0,  40,  0, 0, 11);
    add(0,  0,   1,  1,  0,  0, 0,    0,  40,  0, 0, 12);
    add(0,  0,   1,  1,  0,  0, 0,    0,  40,  0, 0, 13);
    add(0,  0,   0,  1,  0,  0, 0,    1,  40,  1, 0, 14);
    add(0,  0,   0,  0,  0,  0, 0,    0,  40,  1, 0, 14);
    add(1,  1022,0,  0,  0,  0, 0,    0,  40,  0, 0, 14);
    add(0,  1022,0,  0,  0,  0, 0,    0,  1022,0, 0, 0);
    add(0,  0,   0,  0,  0,  0, 0,    1,  1023,0, 0, 1);
    add(0,  0,   0,  0,  0,  0, 0,    1,  0,   1, 1, 2);
    add(0,  0,   0,  0,  0,  0, 0,    0,  0,   1, 1, 2);
    add(1,  50,  0,  0,  0,  0, 0,    0,  0,   0, 1, 2);
    add(1,  50,  0,  0,  0,  0, 0,    0,  50,  0, 0, 0);
    add(0,  50,  0,  0,  0,  0, 0,    0,  50,  0, 0, 0);
    add(0,  0,   0,  1,  1,  1, 2,    1,  50,  1, 0, 1);
    add(1,  30,  0,  0,  0,  0, 0,    0,  50,  0, 0, 1);
    add(0,  30,  0,  0,  0,  0, 0,    0,  30,  0, 0, 0);
    add(0,  0,   0,  0,  0,  0, 0,    1,  31,  0, 0, 1);
    add(1,  5,   0,  0,  0,  0, 0,    0,  31,  0, 0, 2);
    add(0,  5,   0,  0,  0,  0, 0,    0,  5,   0, 0, 0);
    add(0,  0,   0,  0,  0,  0, 0,    1,  6,   0, 0, 1);

    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge Clk);
      drive(int'(vecs[i].start), int'(vecs[i].addr), int'(vecs[i].stall), int'(vecs[i].halt),
            int'(vecs[i].ben), int'(vecs[i].bt), int'(vecs[i].ptr));
      #1;
      chk($sformatf("v%0d_valid", i), int'(InstrValid), int'(vecs[i].valid));
      @(posedge Clk);
      #1;
      chk($sformatf("v%0d_pc", i), int'(ProgCtr), int'(vecs[i].pc));
      chk($sformatf("v%0d_done", i), int'(Done), int'(vecs[i].done));
      chk($sformatf("v%0d_fault", i), int'(Fault), int'(vecs[i].fault));
      chk($sformatf("v%0d_cnt", i), int'(CycleCount), int'(vecs[i].cnt));
    end

    // From PC=6/count=1: 8 stalls then 31 increments -> PC=37, count=40.
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      drive(0, 0, 1, 0, 0, 0, 0);
    end
    for (int k = 0; k < 31; k++) begin
      @(negedge Clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      if (k == 10) begin
        @(posedge Clk);
        #1;
        chk("sat4_first", int'(cnt4), 15);
      end
    end
    @(posedge Clk);
    #1;
    chk("prereset_pc", int'(ProgCtr), 37);
    chk("prereset_cnt", int'(CycleCount), 40);
    chk("sat4_cnt", int'(cnt4), 15);

    #2;
    Reset_n = 1'b0;
    #1;
    chk("midrst_pc", int'(ProgCtr), 0);
    chk("midrst_done", int'(Done), 0);
    chk("midrst_fault", int'(Fault), 0);
    chk("midrst_cnt", int'(CycleCount), 0);
    chk("midrst_valid", int'(InstrValid), 0);
    chk("midrst_cnt4", int'(cnt4), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
